// File: rtl/st_pkg.sv
// st_pkg: opcodes, FSM encoding and constants shared by the stack sequencer
package st_pkg;
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_PUSH  = 8'h01;
    localparam logic [7:0] OP_POP   = 8'h02;
    localparam logic [7:0] OP_ADDSP = 8'h04;
    localparam logic [7:0] OP_SUBSP = 8'h08;
    localparam logic [7:0] OP_MOVSP = 8'h10;
    localparam logic [7:0] OP_ADDS  = 8'h20;
    localparam logic [7:0] OP_LDRSP = 8'h40;
    localparam logic [7:0] OP_STRSP = 8'h80;
    localparam logic [3:0] LR_IDX_DEF = 4'd14;
    localparam logic [3:0] PC_IDX_DEF = 4'd15;
    localparam logic [31:0] WORD_BYTES = 32'd4;
    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM, S_WB, S_FIN} state_t;
endpackage

// File: rtl/st_reglist_scan.sv
// st_reglist_scan: picks the next register of a PUSH/POP mask in either direction
module st_reglist_scan (
    input  logic [8:0] mask,
    input  logic       high_first,
    output logic [3:0] idx,
    output logic       valid
);
    logic [3:0] lo;
    logic [3:0] hi;
    // later hits override earlier ones, so the sweep direction sets the priority
    always_comb begin
        lo = 4'd0;
        hi = 4'd0;
        for (int i = 8; i >= 0; i--) if (mask[i]) lo = 4'(i);
        for (int i = 0; i < 9; i++) if (mask[i]) hi = 4'(i);
    end
    assign idx = high_first ? hi : lo;
    assign valid = |mask;
endmodule

// File: rtl/st_stack_sequencer.sv
// st_stack_sequencer: owns SP and sequences Thumb stack-class instructions
module st_stack_sequencer
    import st_pkg::*;
#(
    parameter logic [31:0] SP_RESET = 32'h0000_1000,
    parameter logic [3:0]  LR_IDX   = LR_IDX_DEF,
    parameter logic [3:0]  PC_IDX   = PC_IDX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  op_sel,
    input  logic [6:0]  immed7,
    input  logic [7:0]  immed8,
    input  logic [8:0]  reg_list,
    input  logic [2:0]  rd,
    input  logic [3:0]  rs,
    output logic        busy,
    output logic        done,
    output logic [31:0] sp,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [3:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata
);
    state_t state_q, state_d;
    logic [31:0] sp_q, sp_d;
    logic [7:0]  op_q, op_d;
    logic [6:0]  imm7_q, imm7_d;
    logic [7:0]  imm8_q, imm8_d;
    logic [8:0]  mask_q, mask_d;
    logic [2:0]  rd_q, rd_d;
    logic [3:0]  rs_q, rs_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  widx_q, widx_d;
    logic [3:0]  idx;
    logic        valid;
    logic        single;
    logic [31:0] off7;
    logic [31:0] off8;
    logic [8:0]  mask_left;

    st_reglist_scan u_scan (
        .mask      (mask_q),
        .high_first(op_q == OP_PUSH),
        .idx       (idx),
        .valid     (valid)
    );

    assign single    = (op_q == OP_LDRSP) || (op_q == OP_STRSP);
    assign off7      = {23'd0, imm7_q, 2'd0};
    assign off8      = {22'd0, imm8_q, 2'd0};
    assign mask_left = mask_q & ~(9'd1 << idx);
    assign busy      = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);
    assign done      = state_q == S_FIN;
    assign sp        = sp_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // next-state, SP update and register-file/memory sequencing
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        op_d        = op_q;
        imm7_d      = imm7_q;
        imm8_d      = imm8_q;
        mask_d      = mask_q;
        rd_d        = rd_q;
        rs_d        = rs_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        widx_d      = widx_q;
        rf_raddr    = 4'd0;
        rf_we       = 1'b0;
        rf_waddr    = 4'd0;
        rf_wdata    = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op_sel;
                    imm7_d  = immed7;
                    imm8_d  = immed8;
                    mask_d  = reg_list;
                    rd_d    = rd;
                    rs_d    = rs;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FIN;
                if (op_q == OP_ADDSP) begin
                    sp_d = sp_q + off7;
                end else if (op_q == OP_SUBSP) begin
                    sp_d = sp_q - off7;
                end else if (op_q == OP_MOVSP) begin
                    rf_raddr = rs_q;
                    sp_d     = {rf_rdata[31:2], 2'b00};
                end else if (op_q == OP_ADDS) begin
                    rf_we    = 1'b1;
                    rf_waddr = {1'b0, rd_q};
                    rf_wdata = sp_q + off8;
                end else if (single) begin
                    state_d = S_MEM;
                end else if ((op_q == OP_PUSH) || (op_q == OP_POP)) begin
                    state_d = valid ? S_MEM : S_FIN;
                end
            end
            S_MEM: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = (op_q == OP_PUSH) || (op_q == OP_STRSP);
                    mem_addr_d  = single ? sp_q + off8 : (op_q == OP_PUSH) ? sp_q - WORD_BYTES : sp_q;
                    rf_raddr    = (op_q == OP_STRSP) ? {1'b0, rd_q} : (idx == 4'd8) ? LR_IDX : idx;
                    mem_wdata_d = rf_rdata;
                end else if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mask_d    = mask_left;
                    sp_d      = single ? sp_q : (op_q == OP_PUSH) ? sp_q - WORD_BYTES : sp_q + WORD_BYTES;
                    rdata_d   = mem_rdata;
                    widx_d    = single ? {1'b0, rd_q} : (idx == 4'd8) ? PC_IDX : idx;
                    state_d   = !mem_we_q ? S_WB : (single || mask_left == 9'd0) ? S_FIN : S_MEM;
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = widx_q;
                rf_wdata = rdata_q;
                state_d  = (single || mask_q == 9'd0) ? S_FIN : S_MEM;
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state registers; reset abandons any transaction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sp_q        <= SP_RESET;
            op_q        <= 8'd0;
            imm7_q      <= 7'd0;
            imm8_q      <= 8'd0;
            mask_q      <= 9'd0;
            rd_q        <= 3'd0;
            rs_q        <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            widx_q      <= 4'd0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            op_q        <= op_d;
            imm7_q      <= imm7_d;
            imm8_q      <= imm8_d;
            mask_q      <= mask_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            widx_q      <= widx_d;
        end
    end
endmodule

// File: tb/tb_st_stack_sequencer.sv
// tb_st_stack_sequencer: scoreboard bench with a transaction-level stack model
module tb_st_stack_sequencer;
    import st_pkg::*;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
    } ev_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  op_sel;
    logic [6:0]  immed7;
    logic [7:0]  immed8;
    logic [8:0]  reg_list;
    logic [2:0]  rd;
    logic [3:0]  rs;
    logic        busy;
    logic        done;
    logic [31:0] sp;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [3:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [31:0] rf [16];
    logic [31:0] m_rf [16];
    logic [31:0] m_sp;
    logic [7:0]  ops [10];
    ev_t         exp_q [$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          done_cnt = 0;
    int          wait_mode = 0;

    st_stack_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op_sel(op_sel), .immed7(immed7),
        .immed8(immed8), .reg_list(reg_list), .rd(rd), .rs(rs), .busy(busy), .done(done),
        .sp(sp), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata)
    );

    assign rf_rdata = rf[rf_raddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic push_ev(input int k, input logic [31:0] a, input logic [31:0] d, input int lat);
        ev_t e;
        e.kind = k;
        e.a = a;
        e.d = d;
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    // kinds: 0 store, 1 load, 2 register write, 3 done (d = sp)
    task automatic check_ev(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d a=%h d=%h", k, a, d);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.a !== a || (k != 1 && e.d !== d)) begin
            failures++;
            $display("FAIL event got kind=%0d a=%h d=%h exp kind=%0d a=%h d=%h", k, a, d, e.kind, e.a, e.d);
        end
        if (k == 3 && e.kind == 3 && e.lat >= 0) chk("latency", 32'(cyc - start_cyc), 32'(e.lat));
    endtask

    // memory responder and output monitor
    initial begin : env_b
        bit in_req;
        bit holding;
        bit prev_ack;
        int wl;
        logic [31:0] h_addr;
        logic [31:0] h_wdata;
        logic h_we;
        in_req = 0;
        holding = 0;
        prev_ack = 0;
        wl = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_req = 0;
                holding = 0;
                prev_ack = 0;
                mem_ack = 1'b0;
                continue;
            end
            if (mem_req && !in_req) begin
                in_req = 1;
                holding = 0;
                wl = (wait_mode < 0) ? int'($urandom_range(3, 0)) : wait_mode;
            end
            mem_ack = in_req && mem_req && wl == 0;
            mem_rdata = mem_ack ? mem_addr >> 2 : $urandom;
            #1;
            if (holding) begin
                chk("req_held", 32'(mem_req), 32'd1);
                chk("addr_stable", mem_addr, h_addr);
                chk("we_stable", 32'(mem_we), 32'(h_we));
                chk("wdata_stable", mem_wdata, h_wdata);
            end
            if (prev_ack) chk("req_drop", 32'(mem_req), 32'd0);
            if (mem_ack) begin
                check_ev(mem_we ? 0 : 1, mem_addr, mem_wdata);
                in_req = 0;
                holding = 0;
            end else if (in_req) begin
                wl--;
                holding = 1;
                h_addr = mem_addr;
                h_we = mem_we;
                h_wdata = mem_wdata;
            end
            if (rf_we) begin
                check_ev(2, {28'd0, rf_waddr}, rf_wdata);
                rf[rf_waddr] = rf_wdata;
            end
            if (done) begin
                check_ev(3, 32'd0, sp);
                done_cnt++;
            end
            prev_ack = mem_ack;
        end
    end

    task automatic set_rf(input int i, input logic [31:0] v);
        rf[i] = v;
        m_rf[i] = v;
    endtask

    task automatic issue(input logic [7:0] op, input logic [6:0] i7, input logic [7:0] i8,
                         input logic [8:0] rl, input logic [2:0] d, input logic [3:0] s,
                         input int wmode, input bit poke);
        int n;
        int r;
        int lat;
        int d0;
        logic [31:0] a;
        n = 0;
        lat = 2;
        case (op)
            OP_ADDSP: m_sp = m_sp + 32'(i7) * 4;
            OP_SUBSP: m_sp = m_sp - 32'(i7) * 4;
            OP_MOVSP: m_sp = m_rf[s] & ~32'd3;
            OP_ADDS: begin
                a = m_sp + 32'(i8) * 4;
                push_ev(2, 32'(d), a, 0);
                m_rf[d] = a;
            end
            OP_LDRSP: begin
                a = m_sp + 32'(i8) * 4;
                push_ev(1, a, 32'd0, 0);
                push_ev(2, 32'(d), a >> 2, 0);
                m_rf[d] = a >> 2;
                lat = -1;
            end
            OP_STRSP: begin
                a = m_sp + 32'(i8) * 4;
                push_ev(0, a, m_rf[d], 0);
                lat = -1;
            end
            OP_PUSH: begin
                for (int b = 8; b >= 0; b--) if (rl[b]) begin
                    r = (b == 8) ? 14 : b;
                    m_sp = m_sp - 4;
                    push_ev(0, m_sp, m_rf[r], 0);
                    n++;
                end
                lat = (wmode == 0) ? 2 + 2 * n : -1;
            end
            OP_POP: begin
                for (int b = 0; b < 9; b++) if (rl[b]) begin
                    r = (b == 8) ? 15 : b;
                    push_ev(1, m_sp, 32'd0, 0);
                    push_ev(2, 32'(r), m_sp >> 2, 0);
                    m_rf[r] = m_sp >> 2;
                    m_sp = m_sp + 4;
                    n++;
                end
                lat = (wmode == 0) ? 2 + 3 * n : -1;
            end
            default: ;
        endcase
        push_ev(3, 32'd0, m_sp, lat);
        wait_mode = wmode;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        op_sel = op;
        immed7 = i7;
        immed8 = i8;
        reg_list = rl;
        rd = d;
        rs = s;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        op_sel = 8'($urandom);
        immed7 = 7'($urandom);
        immed8 = 8'($urandom);
        reg_list = 9'($urandom);
        rd = 3'($urandom);
        rs = 4'($urandom);
        if (poke) begin
            start = 1'b1;
            op_sel = OP_ADDSP;
            immed7 = 7'd5;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("done_seen", 32'(done_cnt != d0), 32'd1);
    endtask

    initial begin
        int n;
        int wm;
        logic [7:0] op;
        reset = 1'b1;
        start = 1'b0;
        op_sel = 8'd0;
        immed7 = 7'd0;
        immed8 = 8'd0;
        reg_list = 9'd0;
        rd = 3'd0;
        rs = 4'd0;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        ops = '{OP_NOP, OP_PUSH, OP_POP, OP_ADDSP, OP_SUBSP, OP_MOVSP, OP_ADDS, OP_LDRSP, OP_STRSP, 8'h03};
        for (int i = 0; i < 16; i++) set_rf(i, $urandom);
        m_sp = 32'h1000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sp", sp, 32'h1000);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(OP_ADDSP, 7'd3, 8'd0, 9'd0, 3'd0, 4'd0, 0, 0);
        chk("addsp_sp", sp, 32'h100C);
        issue(OP_SUBSP, 7'd3, 8'd0, 9'd0, 3'd0, 4'd0, 0, 0);
        for (int i = 0; i < 16; i++) set_rf(i, 32'hA0 + 32'(i));
        issue(OP_PUSH, 7'd0, 8'd0, 9'h105, 3'd0, 4'd0, 0, 1);
        chk("push_sp", sp, 32'hFF4);
        issue(OP_POP, 7'd0, 8'd0, 9'h105, 3'd0, 4'd0, 0, 0);
        chk("pop_sp", sp, 32'h1000);
        issue(OP_LDRSP, 7'd0, 8'd2, 9'd0, 3'd3, 4'd0, 3, 0);
        chk("ldr_sp", sp, 32'h1000);
        set_rf(5, 32'h2003);
        issue(OP_MOVSP, 7'd0, 8'd0, 9'd0, 3'd0, 4'd5, 0, 0);
        chk("movsp_sp", sp, 32'h2000);
        set_rf(6, 32'h0);
        issue(OP_MOVSP, 7'd0, 8'd0, 9'd0, 3'd0, 4'd6, 0, 0);
        issue(OP_SUBSP, 7'd127, 8'd0, 9'd0, 3'd0, 4'd0, 0, 0);
        chk("subsp_wrap", sp, 32'hFFFF_FE04);
        issue(OP_PUSH, 7'd0, 8'd0, 9'd0, 3'd0, 4'd0, 0, 0);
        for (int t = 0; t < 80; t++) begin
            op = ops[$urandom_range(9, 0)];
            wm = ($urandom_range(1, 0) == 0) ? 0 : -1;
            issue(op, 7'($urandom), 8'($urandom), 9'($urandom), 3'($urandom), 4'($urandom),
                  wm, 1'($urandom_range(1, 0)));
        end
        wait_mode = 6;
        @(negedge clk);
        start = 1'b1;
        op_sel = OP_PUSH;
        reg_list = 9'h1FF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        op_sel = OP_ADDSP;
        immed7 = 7'd7;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midpush_req", 32'(mem_req), 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_async_req", 32'(mem_req), 32'd0);
        chk("rst_async_sp", sp, 32'h1000);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_done", 32'(done), 32'd0);
        exp_q.delete();
        m_sp = 32'h1000;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        issue(OP_ADDSP, 7'd1, 8'd0, 9'd0, 3'd0, 4'd0, 0, 0);
        chk("post_rst_sp", sp, 32'h1004);
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
